uart_transmitter: RTL and testbench

//  Serial TX half of the team's UART: accepts a parallel byte on a one-cycle

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_transmitter.sv | 127 ++++++++++++
 tb/tb_uart_transmitter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM state encoding, oversampling ratio
// and default frame parameters used by both the transmitter and receiver.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } uart_state_t;

endpackage

// File: rtl/uart_transmitter.sv
// Serial TX half of the UART. A one-clock tx_start strobe latches din and
// the byte is shifted out as start bit, DBIT data bits (LSB first) and a
// stop bit. Bit timing is counted in 16x baud ticks from the shared s_tick.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            tx_busy
);

  // Bit counter needs at least one bit even for single-bit frames.
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]    S_BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  uart_state_t     state_reg, state_next;
  logic [4:0]      s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            done_next;

  // State, counters, shift register and the line driver are all registered
  // here; reset is synchronous and does not wait for a baud tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic: counters only move on s_tick, except the accept in
  // IDLE which happens on any clock and swallows a coincident tick.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          state_next = START;
          s_next     = '0;
          n_next     = '0;
          b_next     = din;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + NW'(1);
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        s_next     = '0;
        n_next     = '0;
        b_next     = '0;
      end
    endcase
  end

  // The pin value is decoded from the upcoming state so the registered tx
  // changes on the same edge as the state it belongs to.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx           = tx_reg;
  assign tx_done_tick = done_next;
  assign tx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: an 8N1 instance and a 7-bit / 2-stop-bit
// instance, driven with directed and random frames and compared against a
// tick-domain model of the expected serial waveform.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start8 = 1'b0;
  logic [7:0] din8 = '0;
  logic       tx_start7 = 1'b0;
  logic [6:0] din7 = '0;
  logic       tx8, done8, busy8;
  logic       tx7, done7, busy7;

  int cur_sel = 0;
  logic cur_tx, cur_done, cur_busy;
  int check_count = 0;
  int pass_count = 0;
  int tick_div = 0;

  uart_transmitter #(.DBIT(8), .SB_TICK(16)) dut8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start8),
    .din(din8), .tx(tx8), .tx_done_tick(done8), .tx_busy(busy8)
  );

  uart_transmitter #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start7),
    .din(din7), .tx(tx7), .tx_done_tick(done7), .tx_busy(busy7)
  );

  // Observed outputs of whichever instance the current test is driving.
  always_comb begin
    cur_tx   = (cur_sel != 0) ? tx7   : tx8;
    cur_done = (cur_sel != 0) ? done7 : done8;
    cur_busy = (cur_sel != 0) ? busy7 : busy8;
  end

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Baud tick once every 4 clocks, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_div = (tick_div + 1) % 4;
      s_tick = (tick_div == 0);
    end
  end

  // Expected line level for bit slot idx of a frame.
  function automatic logic model_bit(input logic [7:0] data, input int dbit, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= dbit) return data[idx-1];
    return 1'b1;
  endfunction

  task automatic set_start(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin
      tx_start7 = v;
      din7 = d[6:0];
    end else begin
      tx_start8 = v;
      din8 = d;
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!s_tick && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_count++;
    if (!s_tick) $display("[TB] FAIL wait_tick: s_tick got %b want 1 within 8 clks", s_tick);
    else pass_count++;
  endtask

  // Sends one frame (called on a negedge) and follows it to the end.
  task automatic run_frame(input int sel, input logic [7:0] data, input int glitch_at,
                           input logic [7:0] glitch_din, input bit check_len, input string name);
    int dbit, total, ticks, busy_clks, done_cnt, done_at, clks, last_ck;
    bit done_on_tick, aligned, timed_out, glitched;
    logic exp;
    cur_sel = sel;
    dbit = (sel != 0) ? 7 : 8;
    total = 16 * (1 + dbit) + ((sel != 0) ? 32 : 16);
    aligned = s_tick;
    set_start(sel, 1'b1, data);
    @(negedge clk);
    set_start(sel, 1'b0, 8'($urandom));
    ticks = 0; busy_clks = 0; done_cnt = 0; done_at = -1; clks = 0;
    last_ck = -1; timed_out = 0; glitched = 0; done_on_tick = 0;
    while (ticks < total) begin
      if (clks > 4 * total + 16) begin
        timed_out = 1;
        break;
      end
      set_start(sel, 1'b0, (sel != 0) ? {1'b0, din7} : din8);
      if (ticks != last_ck && (ticks % 16 == 0 || ticks % 16 == 8)) begin
        last_ck = ticks;
        exp = model_bit(data, dbit, ticks / 16);
        check_count++;
        if (cur_tx !== exp)
          $display("[TB] FAIL %s tx: got %b want %b at tick %0d", name, cur_tx, exp, ticks);
        else pass_count++;
        check_count++;
        if (cur_busy !== 1'b1)
          $display("[TB] FAIL %s busy: got %b want 1 at tick %0d", name, cur_busy, ticks);
        else pass_count++;
      end
      if (ticks == glitch_at && s_tick && !glitched) begin
        glitched = 1;
        set_start(sel, 1'b1, glitch_din);
      end
      if (cur_busy === 1'b1) busy_clks++;
      if (cur_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = ticks;
          done_on_tick = s_tick;
        end
      end
      if (s_tick) ticks++;
      clks++;
      @(negedge clk);
    end
    set_start(sel, 1'b0, (sel != 0) ? {1'b0, din7} : din8);
    check_count++;
    if (timed_out) $display("[TB] FAIL %s timeout: got %0d ticks want %0d", name, ticks, total);
    else pass_count++;
    check_count++;
    if (done_cnt != 1) $display("[TB] FAIL %s done_count: got %0d want 1", name, done_cnt);
    else pass_count++;
    check_count++;
    if (done_at != total - 1 || !done_on_tick)
      $display("[TB] FAIL %s done_position: got tick %0d (s_tick %b) want tick %0d (s_tick 1)",
               name, done_at, done_on_tick, total - 1);
    else pass_count++;
    if (check_len && aligned) begin
      check_count++;
      if (busy_clks != 4 * total)
        $display("[TB] FAIL %s frame_clks: got %0d want %0d", name, busy_clks, 4 * total);
      else pass_count++;
    end
    check_count++;
    if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0)
      $display("[TB] FAIL %s idle_after: got tx=%b busy=%b done=%b want 1/0/0",
               name, cur_tx, cur_busy, cur_done);
    else pass_count++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_count++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0)
        $display("[TB] FAIL reset8: got tx=%b busy=%b done=%b want 1/0/0", tx8, busy8, done8);
      else pass_count++;
      check_count++;
      if (tx7 !== 1'b1 || busy7 !== 1'b0 || done7 !== 1'b0)
        $display("[TB] FAIL reset7: got tx=%b busy=%b done=%b want 1/0/0", tx7, busy7, done7);
      else pass_count++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    wait_tick();
    run_frame(0, 8'hA5, -1, 8'h00, 1, "frame_a5");
  endtask

  task automatic test_ignore_mid_frame();
    wait_tick();
    run_frame(0, 8'hA5, 16 * 3 + 5, 8'h00, 1, "ignore_mid");
  endtask

  task automatic test_back_to_back();
    wait_tick();
    run_frame(0, 8'hA5, 16 * 10 - 1, 8'h5A, 1, "b2b_first");
    run_frame(0, 8'hFF, -1, 8'h00, 0, "b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    int ticks, clks, done_seen, tx_low;
    wait_tick();
    cur_sel = 0;
    set_start(0, 1'b1, 8'($urandom));
    @(negedge clk);
    set_start(0, 1'b0, 8'($urandom));
    ticks = 0; clks = 0;
    while (ticks < 16 * 4 + 8 && clks < 400) begin
      if (s_tick) ticks++;
      clks++;
      @(negedge clk);
    end
    check_count++;
    if (clks >= 400 || cur_busy !== 1'b1)
      $display("[TB] FAIL rst_mid_setup: got busy=%b clks=%0d want busy=1 in frame", cur_busy, clks);
    else pass_count++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_count++;
    if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0)
      $display("[TB] FAIL rst_mid_abort: got tx=%b busy=%b done=%b want 1/0/0",
               cur_tx, cur_busy, cur_done);
    else pass_count++;
    done_seen = 0; tx_low = 0;
    repeat (300) begin
      if (cur_done === 1'b1) done_seen++;
      if (cur_tx !== 1'b1) tx_low++;
      @(negedge clk);
    end
    check_count++;
    if (done_seen != 0) $display("[TB] FAIL rst_mid_done: got %0d pulses want 0", done_seen);
    else pass_count++;
    check_count++;
    if (tx_low != 0) $display("[TB] FAIL rst_mid_line: got %0d non-idle clks want 0", tx_low);
    else pass_count++;
    run_frame(0, 8'h3C, -1, 8'h00, 0, "after_reset_3c");
  endtask

  task automatic test_dbit7_two_stop();
    wait_tick();
    run_frame(1, 8'h55, -1, 8'h00, 1, "dbit7_55");
  endtask

  task automatic test_random();
    int sel, gap, glitch, total;
    for (int i = 0; i < 10; i++) begin
      sel = (i >= 8) ? 1 : 0;
      total = (sel != 0) ? 16 * 8 + 32 : 16 * 9 + 16;
      gap = $urandom_range(0, 5);
      repeat (gap) @(negedge clk);
      glitch = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, total - 1)) : -1;
      run_frame(sel, 8'($urandom), glitch, 8'($urandom), 0, "random");
    end
  endtask

  initial begin
    $display("[TB] uart_transmitter bench start");
    test_reset();
    test_single_frame();
    test_ignore_mid_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_dbit7_two_stop();
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
